cla_8: RTL and testbench

//  8-bit carry-lookahead adder: s = a + b + ci with carry-out co.

---
 rtl/cla_8.sv | 80 ++++++++
 tb/tb_cla_8.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cla_8.sv
// 8-bit two-level carry-lookahead adder: two 4-bit lookahead groups joined by a
// second-level carry unit, with combinational sum/carry plus registered copies.
module cla_8 (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co,
    output logic       pg,
    output logic       gg,
    output logic [7:0] s_r,
    output logic       co_r
);

    logic [7:0] w_p;
    logic [7:0] w_g;
    logic [7:0] w_c;
    logic [1:0] w_grp_p;
    logic [1:0] w_grp_g;
    logic [1:0] w_grp_cin;
    logic       w_c8;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Group carry-ins come only from the second-level unit, never from a ripple.
    assign w_grp_cin[0] = ci;
    assign w_grp_cin[1] = w_grp_g[0] | (w_grp_p[0] & ci);

    assign w_c8 = w_grp_g[1] | (w_grp_p[1] & w_grp_g[0])
                | (w_grp_p[1] & w_grp_p[0] & ci);

    for (genvar k = 0; k < 2; k++) begin : g_grp
        logic [3:0] w_gp;
        logic [3:0] w_gg;
        logic       w_c0;

        assign w_gp = w_p[4*k +: 4];
        assign w_gg = w_g[4*k +: 4];
        assign w_c0 = w_grp_cin[k];

        // Every internal carry is a flat sum of products of the group inputs.
        assign w_c[4*k + 0] = w_c0;
        assign w_c[4*k + 1] = w_gg[0] | (w_gp[0] & w_c0);
        assign w_c[4*k + 2] = w_gg[1] | (w_gp[1] & w_gg[0])
                            | (w_gp[1] & w_gp[0] & w_c0);
        assign w_c[4*k + 3] = w_gg[2] | (w_gp[2] & w_gg[1])
                            | (w_gp[2] & w_gp[1] & w_gg[0])
                            | (w_gp[2] & w_gp[1] & w_gp[0] & w_c0);

        assign w_grp_p[k] = &w_gp;
        assign w_grp_g[k] = w_gg[3] | (w_gp[3] & w_gg[2])
                          | (w_gp[3] & w_gp[2] & w_gg[1])
                          | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);
    end

    assign s  = w_p ^ w_c;
    assign co = w_c8;
    assign pg = w_grp_p[1] & w_grp_p[0];
    assign gg = w_grp_g[1] | (w_grp_p[1] & w_grp_g[0]);

    logic [7:0] r_s;
    logic       r_co;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s  <= 8'h00;
            r_co <= 1'b0;
        end else begin
            r_s  <= s;
            r_co <= co;
        end
    end

    assign s_r  = r_s;
    assign co_r = r_co;

endmodule

// File: tb/tb_cla_8.sv
// Bench for cla_8: directed corner vectors, reset behaviour of the registered path,
// and a random sweep compared against plain a+b+ci arithmetic.
module tb_cla_8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       pg;
    logic       gg;
    logic [7:0] s_r;
    logic       co_r;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] exp_q[$];

    cla_8 dut (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .b    (b),
        .ci   (ci),
        .s    (s),
        .co   (co),
        .pg   (pg),
        .gg   (gg),
        .s_r  (s_r),
        .co_r (co_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (a=%0h b=%0h ci=%0b)",
                     tag, observed, expected, a, b, ci);
        end
    endtask

    // Drive inputs and compare the combinational outputs against arithmetic.
    task automatic apply(input logic [7:0] av, input logic [7:0] bv, input logic civ);
        int sum;
        int sum_nc;
        a  = av;
        b  = bv;
        ci = civ;
        #1;
        sum    = int'(av) + int'(bv) + int'(civ);
        sum_nc = int'(av) + int'(bv);
        check("s",  32'(s),  32'(sum % 256));
        check("co", 32'(co), 32'(sum / 256));
        check("pg", 32'(pg), 32'((av ^ bv) == 8'hFF));
        check("gg", 32'(gg), 32'(sum_nc / 256));
    endtask

    task automatic check_vec(input string tag, input logic [7:0] av, input logic [7:0] bv,
                             input logic civ, input logic [7:0] s_exp, input logic co_exp);
        apply(av, bv, civ);
        check({tag, "_s"},  32'(s),  32'(s_exp));
        check({tag, "_co"}, 32'(co), 32'(co_exp));
    endtask

    initial begin
        reset = 1'b1;
        a     = 8'h00;
        b     = 8'h00;
        ci    = 1'b0;
        #1;
        check("rst_s_r",  32'(s_r),  32'h00);
        check("rst_co_r", 32'(co_r), 32'h0);

        check_vec("v0",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        check_vec("v1",  8'h01, 8'h00, 1'b1, 8'h02, 1'b0);
        check_vec("v2",  8'h01, 8'hFE, 1'b1, 8'h00, 1'b1);
        check("v2_pg", 32'(pg), 32'h1);
        check_vec("v3",  8'hD2, 8'hEF, 1'b0, 8'hC1, 1'b1);
        check_vec("v4",  8'h13, 8'hB4, 1'b1, 8'hC8, 1'b0);
        check_vec("v5",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        check_vec("v6",  8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1);
        check_vec("v7",  8'h08, 8'h08, 1'b0, 8'h10, 1'b0);

        // Registers must stay cleared across an edge while reset is held.
        @(posedge clk);
        #1;
        check("held_s_r",  32'(s_r),  32'h00);
        check("held_co_r", 32'(co_r), 32'h0);

        @(negedge clk);
        reset = 1'b0;
        apply(8'hD2, 8'hEF, 1'b0);
        @(posedge clk);
        #1;
        check("reg_s_r",  32'(s_r),  32'hC1);
        check("reg_co_r", 32'(co_r), 32'h1);

        #2;
        reset = 1'b1;
        #1;
        check("async_s_r",  32'(s_r),  32'h00);
        check("async_co_r", 32'(co_r), 32'h0);
        check("async_s",    32'(s),    32'hC1);
        apply(8'h13, 8'hB4, 1'b1);
        @(posedge clk);
        #1;
        check("async_held_s_r", 32'(s_r), 32'h00);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] av;
            logic [7:0] bv;
            logic       civ;
            int         sum;
            @(negedge clk);
            av  = 8'($urandom_range(0, 255));
            bv  = 8'($urandom_range(0, 255));
            civ = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: bv = ~av;
                1: begin av = 8'hFF; bv = 8'hFF; end
                default: ;
            endcase
            apply(av, bv, civ);
            sum = int'(av) + int'(bv) + int'(civ);
            exp_q.push_back(9'(sum));
            @(posedge clk);
            #1;
            check("rand_reg", 32'({co_r, s_r}), 32'(exp_q.pop_front()));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
